// File: rtl/regex_instr_mem_server_pkg.sv
// Shared sizing defaults for the regex_cpu fetch interface and its instruction server.
// No opcode types live here; this only keeps word/address widths in one place.
package instruction_package;

    localparam int unsigned DEFAULT_N_PORTS           = 2;
    localparam int unsigned DEFAULT_MEMORY_WIDTH      = 20;
    localparam int unsigned DEFAULT_MEMORY_ADDR_WIDTH = 11;

    // Width of a port index; a single-port build still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regex_instr_mem_server_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting, unmasked port at or after ptr.
// Purely combinational; the caller owns the pointer and mask registers.
module regex_rr_arbiter
    import instruction_package::*;
#(
    parameter int unsigned N_PORTS = DEFAULT_N_PORTS,
    localparam int unsigned IDX_W  = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [N_PORTS-1:0] eligible;
    logic [IDX_W-1:0]   idx;
    int unsigned        pos;
    logic               found;

    always_comb begin
        eligible  = req & ~mask;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            // ptr is always below N_PORTS, so one conditional subtract wraps it
            pos = 32'(ptr) + k;
            if (pos >= N_PORTS) begin
                pos = pos - N_PORTS;
            end
            idx = IDX_W'(pos);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regex_instr_mem_server.sv
// Instruction-memory responder for N_PORTS regex_cpu fetch ports: round-robin grant,
// one-cycle ready pulse, pipelined single-port RAM read, loader write with priority.
module regex_instr_mem_server
    import instruction_package::*;
#(
    parameter int unsigned N_PORTS           = DEFAULT_N_PORTS,
    parameter int unsigned MEMORY_WIDTH      = DEFAULT_MEMORY_WIDTH,
    parameter int unsigned MEMORY_ADDR_WIDTH = DEFAULT_MEMORY_ADDR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_PORTS-1:0]                   memory_valid,
    input  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr,
    output logic [N_PORTS-1:0]                   memory_ready,
    output logic [N_PORTS*MEMORY_WIDTH-1:0]      memory_data,
    input  logic                                 load_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0]         load_addr,
    input  logic [MEMORY_WIDTH-1:0]              load_data,
    output logic                                 busy
);

    localparam int unsigned IDX_W = idx_width(N_PORTS);
    localparam int unsigned DEPTH = 1 << MEMORY_ADDR_WIDTH;

    logic [MEMORY_WIDTH-1:0]      mem [DEPTH];

    logic [MEMORY_ADDR_WIDTH-1:0] port_addr [N_PORTS];
    logic [MEMORY_WIDTH-1:0]      data_q    [N_PORTS];

    logic [N_PORTS-1:0]           req;
    logic [N_PORTS-1:0]           grant;
    logic [IDX_W-1:0]             grant_idx;
    logic                         grant_any;
    logic [IDX_W-1:0]             next_ptr;
    logic [MEMORY_ADDR_WIDTH-1:0] sel_addr;

    logic [N_PORTS-1:0]           ready_q;
    logic [IDX_W-1:0]             rr_ptr;
    logic                         pend_valid;
    logic [IDX_W-1:0]             pend_port;
    logic [MEMORY_ADDR_WIDTH-1:0] pend_addr;

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            port_addr[i] = memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
        end
    end

    // A loader write owns the RAM port for the cycle, so it suppresses every request.
    assign req = memory_valid & {N_PORTS{~load_en}};

    // Masking last cycle's winner keeps a lagging valid from being served twice.
    regex_rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_arbiter (
        .req       (req),
        .mask      (ready_q),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        grant_any = |grant;
        sel_addr  = port_addr[grant_idx];
        next_ptr  = (32'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= '0;
            rr_ptr     <= '0;
            pend_valid <= 1'b0;
            pend_port  <= '0;
            pend_addr  <= '0;
        end else begin
            ready_q    <= grant;
            pend_valid <= grant_any;
            if (grant_any) begin
                pend_port <= grant_idx;
                pend_addr <= sel_addr;
                rr_ptr    <= next_ptr;
            end
        end
    end

    // RAM contents survive reset; a pending read sees the pre-write word on collision.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                data_q[i] <= '0;
            end
        end else if (pend_valid) begin
            data_q[pend_port] <= mem[pend_addr];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] = data_q[i];
        end
    end

    assign memory_ready = ready_q;
    assign busy         = (|ready_q) | pend_valid;

endmodule
